// File: rtl/muldiv_unit_pkg.sv
// Shared constants, op encodings and FSM state type for the iterative RV32M multiply/divide unit.
package muldiv_unit_pkg;

    localparam int WIDTH = 32;
    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: one bit per clock on operand magnitudes, sign fixed up at the end.
// Handshake: an op is accepted on a rising edge where start_in=1 and ready_out=1; valid_out pulses one cycle with the result.
module muldiv_unit
    import muldiv_unit_pkg::*;
(
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             start_in,
    input  logic [2:0]       funct3_in,
    input  logic [WIDTH-1:0] op_a_in,
    input  logic [WIDTH-1:0] op_b_in,
    input  logic [4:0]       rd_in,
    output logic             ready_out,
    output logic             valid_out,
    output logic [WIDTH-1:0] result_out,
    output logic [4:0]       rd_out,
    output logic             wr_en_out,
    output logic [1:0]       state_out
);

    state_t state, state_next;

    logic [CNT_W-1:0]   count;
    logic [2*WIDTH-1:0] acc, acc_step, prod_fix;
    logic [WIDTH-1:0]   op_mag;
    logic [2:0]         funct3;
    logic               neg;
    logic [4:0]         rd_q;

    logic               sign_a, sign_b, a_neg, b_neg, neg_in;
    logic [WIDTH-1:0]   mag_a, mag_b, special_result, result_fin;
    logic               div_zero, div_ovf, special, accept, finish;
    logic [WIDTH:0]     sum, rem_shift;
    logic [WIDTH+1:0]   diff;

    // Decode of the request presented at the inputs (used only at the accept edge).
    always_comb begin
        sign_a   = (funct3_in == MD_MULH) || (funct3_in == MD_MULHSU) ||
                   (funct3_in == MD_DIV)  || (funct3_in == MD_REM);
        sign_b   = (funct3_in == MD_MULH) || (funct3_in == MD_DIV) || (funct3_in == MD_REM);
        a_neg    = sign_a & op_a_in[WIDTH-1];
        b_neg    = sign_b & op_b_in[WIDTH-1];
        mag_a    = a_neg ? -op_a_in : op_a_in;
        mag_b    = b_neg ? -op_b_in : op_b_in;
        neg_in   = (funct3_in == MD_REM) ? a_neg : (a_neg ^ b_neg);
        div_zero = funct3_in[2] && (op_b_in == '0);
        div_ovf  = ((funct3_in == MD_DIV) || (funct3_in == MD_REM)) &&
                   (op_a_in == {1'b1, {(WIDTH-1){1'b0}}}) && (op_b_in == '1);
        special  = div_zero | div_ovf;
        special_result = '0;
        if (div_zero)
            special_result = funct3_in[1] ? op_a_in : '1;
        else if (div_ovf)
            special_result = funct3_in[1] ? '0 : op_a_in;
        accept = (state == ST_IDLE) && start_in;
        finish = (state == ST_CALC) && (count == CNT_W'(1));
    end

    // One iteration: shift-add for multiply (product builds in acc), restoring step for divide
    // (acc = {remainder, dividend/quotient}); the remainder window is one bit wider to hold the carry-out.
    always_comb begin
        sum       = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, op_mag};
        rem_shift = acc[2*WIDTH-1:WIDTH-1];
        diff      = {1'b0, rem_shift} - {2'b00, op_mag};
        acc_step  = {1'b0, acc[2*WIDTH-1:1]};
        if (funct3[2]) begin
            if (!diff[WIDTH+1])
                acc_step = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else
                acc_step = {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end else if (acc[0]) begin
            acc_step = {sum, acc[WIDTH-1:1]};
        end
        prod_fix = neg ? -acc_step : acc_step;
        case (funct3)
            MD_MUL:          result_fin = acc_step[WIDTH-1:0];
            MD_DIV, MD_DIVU: result_fin = neg ? -acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0];
            MD_REM, MD_REMU: result_fin = neg ? -acc_step[2*WIDTH-1:WIDTH] : acc_step[2*WIDTH-1:WIDTH];
            default:         result_fin = prod_fix[2*WIDTH-1:WIDTH];
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start_in) state_next = special ? ST_DONE : ST_CALC;
            ST_CALC: if (finish)   state_next = ST_DONE;
            ST_DONE:               state_next = ST_IDLE;
            default:               state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            count      <= '0;
            acc        <= '0;
            op_mag     <= '0;
            funct3     <= '0;
            neg        <= 1'b0;
            rd_q       <= '0;
            result_out <= '0;
            rd_out     <= '0;
        end else if (accept) begin
            funct3 <= funct3_in;
            neg    <= neg_in;
            rd_q   <= rd_in;
            if (special) begin
                result_out <= special_result;
                rd_out     <= rd_in;
            end else begin
                count  <= CNT_W'(WIDTH);
                op_mag <= funct3_in[2] ? mag_b : mag_a;
                acc    <= {{WIDTH{1'b0}}, (funct3_in[2] ? mag_a : mag_b)};
            end
        end else if (state == ST_CALC) begin
            count <= count - 1'b1;
            acc   <= acc_step;
            if (finish) begin
                result_out <= result_fin;
                rd_out     <= rd_q;
            end
        end
    end

    assign ready_out = (state == ST_IDLE);
    assign valid_out = (state == ST_DONE);
    assign wr_en_out = valid_out & (|rd_out);
    assign state_out = state;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit with a small register-file model standing in for regbank.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic             clk_in = 1'b0;
    logic             rst_in = 1'b1;
    logic             start_in = 1'b0;
    logic [2:0]       funct3_in = '0;
    logic [WIDTH-1:0] op_a_in = '0;
    logic [WIDTH-1:0] op_b_in = '0;
    logic [4:0]       rd_in = '0;
    logic             ready_out, valid_out, wr_en_out;
    logic [WIDTH-1:0] result_out;
    logic [4:0]       rd_out;
    logic [1:0]       state_out;

    muldiv_unit dut (
        .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .funct3_in(funct3_in),
        .op_a_in(op_a_in), .op_b_in(op_b_in), .rd_in(rd_in), .ready_out(ready_out),
        .valid_out(valid_out), .result_out(result_out), .rd_out(rd_out),
        .wr_en_out(wr_en_out), .state_out(state_out)
    );

    // clock / reset block
    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    // regbank model: bench preload port plus the unit's write-back port
    logic [WIDTH-1:0] regs [32];
    logic             tb_wr = 1'b0;
    logic [4:0]       tb_addr = '0;
    logic [WIDTH-1:0] tb_data = '0;
    always @(posedge clk_in) begin
        if (tb_wr)
            regs[tb_addr] <= tb_data;
        else if (wr_en_out)
            regs[rd_out] <= result_out;
    end

    int checks = 0;
    int passes = 0;

    logic [WIDTH-1:0] exp_q[$];
    logic [4:0]       exp_rd_q[$];
    int               exp_lat_q[$];
    int               acc_cyc_q[$];

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s actual=%h required=%h", name, act, req);
    endtask

    // scoreboard monitor
    always @(negedge clk_in) begin
        if (!rst_in && valid_out) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                logic [WIDTH-1:0] e;
                logic [4:0]       erd;
                int               elat, acyc;
                e    = exp_q.pop_front();
                erd  = exp_rd_q.pop_front();
                elat = exp_lat_q.pop_front();
                acyc = acc_cyc_q.pop_front();
                check("result", result_out, e);
                check("rd_out", 32'(rd_out), 32'(erd));
                check("wr_en", 32'(wr_en_out), 32'(erd != 5'd0));
                check("latency", 32'(cyc - acyc + 1), 32'(elat));
            end
        end
    end

    // driver tasks
    task automatic wait_ready();
        int guard = 0;
        @(negedge clk_in);
        while (!ready_out && guard < 200) begin
            @(negedge clk_in);
            guard++;
        end
        if (!ready_out) check("ready_timeout", 32'(ready_out), 32'd1);
    endtask

    task automatic issue(input logic [2:0] f, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [4:0] rd, input logic [WIDTH-1:0] exp, input int lat);
        wait_ready();
        start_in = 1'b1; funct3_in = f; op_a_in = a; op_b_in = b; rd_in = rd;
        @(posedge clk_in);
        #1;
        exp_q.push_back(exp);
        exp_rd_q.push_back(rd);
        exp_lat_q.push_back(lat);
        acc_cyc_q.push_back(cyc);
        start_in = 1'b0;
        op_a_in = $urandom; op_b_in = $urandom; rd_in = 5'($urandom_range(0, 31));
        funct3_in = 3'($urandom_range(0, 7));
    endtask

    task automatic wait_idle();
        int guard = 0;
        @(negedge clk_in);
        while (!(exp_q.size() == 0 && ready_out) && guard < 300) begin
            @(negedge clk_in);
            guard++;
        end
        if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic reg_write(input logic [4:0] addr, input logic [WIDTH-1:0] data);
        @(negedge clk_in);
        tb_wr = 1'b1; tb_addr = addr; tb_data = data;
        @(negedge clk_in);
        tb_wr = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        check("rst_ready", 32'(ready_out), 32'd1);
        check("rst_valid", 32'(valid_out), 32'd0);
        check("rst_wr_en", 32'(wr_en_out), 32'd0);
        check("rst_result", result_out, 32'd0);
        check("rst_rd", 32'(rd_out), 32'd0);
        check("rst_state", 32'(state_out), 32'd0);
        rst_in = 1'b0;

        // multiply
        issue(MD_MUL,    32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 33);
        issue(MD_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1,  32'hFFFFFFFE, 33);
        issue(MD_MULH,   32'h80000000, 32'h80000000, 5'd2,  32'h40000000, 33);
        issue(MD_MULHSU, 32'hFFFFFFFF, 32'd2,        5'd3,  32'hFFFFFFFF, 33);
        issue(MD_MULH,   32'hFFFFFFFD, 32'd7,        5'd4,  32'hFFFFFFFF, 33);
        // divide
        issue(MD_DIV,    32'hFFFFFFF9, 32'd2,        5'd8,  32'hFFFFFFFD, 33);
        issue(MD_REM,    32'hFFFFFFF9, 32'd2,        5'd9,  32'hFFFFFFFF, 33);
        issue(MD_DIVU,   32'd100,      32'd7,        5'd10, 32'd14,       33);
        issue(MD_REMU,   32'd100,      32'd7,        5'd11, 32'd2,        33);
        issue(MD_DIV,    32'd7,        32'hFFFFFFFE, 5'd12, 32'hFFFFFFFD, 33);
        issue(MD_REM,    32'd7,        32'hFFFFFFFE, 5'd13, 32'd1,        33);
        issue(MD_DIVU,   32'hFFFFFFFF, 32'd1,        5'd14, 32'hFFFFFFFF, 33);
        // special cases
        issue(MD_DIV,    32'd5,        32'd0,        5'd15, 32'hFFFFFFFF, 1);
        issue(MD_REMU,   32'd5,        32'd0,        5'd16, 32'd5,        1);
        issue(MD_DIV,    32'h80000000, 32'hFFFFFFFF, 5'd17, 32'h80000000, 1);
        issue(MD_REM,    32'h80000000, 32'hFFFFFFFF, 5'd18, 32'd0,        1);

        // start during CALC is dropped
        issue(MD_MUL, 32'd3, 32'd4, 5'd19, 32'd12, 33);
        repeat (5) @(negedge clk_in);
        start_in = 1'b1; funct3_in = MD_DIV; op_a_in = 32'd1; op_b_in = 32'd0; rd_in = 5'd20;
        @(negedge clk_in);
        start_in = 1'b0;
        // x0 destination: completes but never writes
        issue(MD_DIVU, 32'd100, 32'd7, 5'd0, 32'd14, 33);
        wait_idle();

        // reset in the middle of an operation
        reg_write(5'd21, 32'hDEADBEEF);
        wait_ready();
        start_in = 1'b1; funct3_in = MD_MUL; op_a_in = 32'd5; op_b_in = 32'd5; rd_in = 5'd21;
        @(posedge clk_in);
        #1 start_in = 1'b0;
        repeat (9) @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b1;
        @(posedge clk_in);
        #1;
        check("abort_ready", 32'(ready_out), 32'd1);
        check("abort_valid", 32'(valid_out), 32'd0);
        check("abort_wr_en", 32'(wr_en_out), 32'd0);
        @(negedge clk_in);
        rst_in = 1'b0;
        repeat (40) @(negedge clk_in);
        check("abort_no_write", regs[21], 32'hDEADBEEF);

        // regbank integration
        reg_write(5'd6, 32'h0000000C);
        reg_write(5'd3, 32'h00000005);
        issue(MD_MUL, regs[6], regs[3], 5'd7, 32'h0000003C, 33);
        wait_idle();
        check("x7_mul", regs[7], 32'h0000003C);
        issue(MD_DIVU, regs[6], regs[3], 5'd7, 32'h00000002, 33);
        wait_idle();
        check("x7_divu", regs[7], 32'h00000002);

        repeat (5) @(negedge clk_in);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
